uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter among `N_REQ` byte-stream requesters, such as the register read-back path, the status reporter and the debug dump. It sits between the requesters and the transmitter's `din`/`wr_en`/`txd_busy` interface. It locks the grant to one requester for a whole packet (bytes up to and including `req_last`) and releases a stalled owner after a timeout. It also paces writes so that only one byte is in flight at a time.

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// The master side is the environment (requesters plus transmitter); the slave is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   grant;
    logic [7:0]         tx_din;
    logic               tx_wr_en;
    logic               tx_busy;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, grant, tx_din, tx_wr_en
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, grant, tx_din, tx_wr_en
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte streams,
// with per-packet locking, stalled-owner timeout and one-byte-in-flight pacing.
module uart_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TIMEOUT  = 4096,
    parameter int RISE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus,
    output logic             timeout_pulse,
    output logic [2:0]       timeout_id
);
    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_SAT   = {TW{1'b1}};
    localparam logic [2:0]    RISE_LAST = 3'(RISE_MAX - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        HOLD      = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       owner_q, owner_d;
    logic [2:0]       last_owner_q, last_owner_d;
    logic             pkt_end_q, pkt_end_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [2:0]       rise_cnt_q, rise_cnt_d;
    logic [7:0]       tx_din_q, tx_din_d;
    logic             tx_wr_en_q, tx_wr_en_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             timeout_pulse_q, timeout_pulse_d;
    logic [2:0]       timeout_id_q, timeout_id_d;

    logic             cand_found_s;
    logic [2:0]       cand_idx_s;
    logic [3:0]       scan_sum_s;
    logic [2:0]       scan_idx_s;
    logic             scan_hit_s;
    logic [2:0]       sel_idx_s;
    logic             sel_valid_s;
    logic             sel_last_s;
    logic [7:0]       sel_data_s;
    logic             xfer_s;
    logic [N_REQ-1:0] ready_s;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        cand_found_s = 1'b0;
        cand_idx_s   = 3'd0;
        scan_sum_s   = 4'd0;
        scan_idx_s   = 3'd0;
        scan_hit_s   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_sum_s = {1'b0, last_owner_q} + 4'(k);
            scan_idx_s = (scan_sum_s >= 4'(N_REQ)) ? 3'(scan_sum_s - 4'(N_REQ)) : scan_sum_s[2:0];
            scan_hit_s = 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                scan_hit_s = scan_hit_s | (bus.req_valid[i] & (3'(i) == scan_idx_s));
            end
            cand_idx_s   = (scan_hit_s && !cand_found_s) ? scan_idx_s : cand_idx_s;
            cand_found_s = cand_found_s | scan_hit_s;
        end
    end

    assign sel_idx_s = (state_q == IDLE) ? cand_idx_s : owner_q;

    // Lane mux for the requester currently being offered the transmitter.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            sel_valid_s = sel_valid_s | (bus.req_valid[i] & (3'(i) == sel_idx_s));
            sel_last_s  = sel_last_s  | (bus.req_last[i]  & (3'(i) == sel_idx_s));
            sel_data_s  = sel_data_s  | (bus.req_data[8*i +: 8] & {8{3'(i) == sel_idx_s}});
        end
    end

    // Ready is offered only while the transmitter is idle, so a byte never overlaps a frame.
    always_comb begin
        ready_s = '0;
        if (rst || bus.tx_busy) begin
            xfer_s = 1'b0;
        end else if (state_q == IDLE) begin
            xfer_s = cand_found_s;
        end else if (state_q == HOLD) begin
            xfer_s = sel_valid_s;
        end else begin
            xfer_s = 1'b0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            ready_s[i] = xfer_s & (3'(i) == sel_idx_s);
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_owner_d    = last_owner_q;
        pkt_end_d       = pkt_end_q;
        tmo_cnt_d       = tmo_cnt_q;
        rise_cnt_d      = rise_cnt_q;
        tx_din_d        = tx_din_q;
        tx_wr_en_d      = 1'b0;
        grant_d         = grant_q;
        timeout_pulse_d = 1'b0;
        timeout_id_d    = timeout_id_q;
        case (state_q)
            IDLE: begin
                if (xfer_s) begin
                    owner_d    = sel_idx_s;
                    grant_d    = ready_s;
                    tx_din_d   = sel_data_s;
                    pkt_end_d  = sel_last_s;
                    tx_wr_en_d = 1'b1;
                    state_d    = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                rise_cnt_d = 3'd0;
                state_d    = WAIT_RISE;
            end
            WAIT_RISE: begin
                // A transmitter that never raises busy must not hang the arbiter.
                if (bus.tx_busy || (rise_cnt_q == RISE_LAST)) begin
                    state_d = WAIT_FALL;
                end else begin
                    rise_cnt_d = rise_cnt_q + 3'd1;
                end
            end
            WAIT_FALL: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_FALL;
                end else if (pkt_end_q) begin
                    last_owner_d = owner_q;
                    grant_d      = '0;
                    state_d      = IDLE;
                end else begin
                    tmo_cnt_d = '0;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (xfer_s) begin
                    tx_din_d   = sel_data_s;
                    pkt_end_d  = sel_last_s;
                    tmo_cnt_d  = '0;
                    tx_wr_en_d = 1'b1;
                    state_d    = SEND;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_pulse_d = 1'b1;
                    timeout_id_d    = owner_q;
                    last_owner_d    = owner_q;
                    grant_d         = '0;
                    state_d         = IDLE;
                end else begin
                    tmo_cnt_d = (tmo_cnt_q == TMO_SAT) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            owner_q         <= 3'd0;
            last_owner_q    <= 3'(N_REQ - 1);
            pkt_end_q       <= 1'b0;
            tmo_cnt_q       <= '0;
            rise_cnt_q      <= 3'd0;
            tx_din_q        <= 8'h00;
            tx_wr_en_q      <= 1'b0;
            grant_q         <= '0;
            timeout_pulse_q <= 1'b0;
            timeout_id_q    <= 3'd0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_owner_q    <= last_owner_d;
            pkt_end_q       <= pkt_end_d;
            tmo_cnt_q       <= tmo_cnt_d;
            rise_cnt_q      <= rise_cnt_d;
            tx_din_q        <= tx_din_d;
            tx_wr_en_q      <= tx_wr_en_d;
            grant_q         <= grant_d;
            timeout_pulse_q <= timeout_pulse_d;
            timeout_id_q    <= timeout_id_d;
        end
    end

    assign bus.req_ready  = ready_s;
    assign bus.grant      = grant_q;
    assign bus.tx_din     = tx_din_q;
    assign bus.tx_wr_en   = tx_wr_en_q;
    assign timeout_pulse  = timeout_pulse_q;
    assign timeout_id     = timeout_id_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requester packets, a behavioural transmitter and
// a packet-level round-robin model predicting the byte stream.
module tb_uart_tx_arbiter;
    localparam int N    = 4;
    localparam int TMO  = 16;
    localparam int RISE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       timeout_pulse;
    logic [2:0] timeout_id;

    uart_tx_arbiter_if #(.N_REQ(N)) ifc ();

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO), .RISE_MAX(RISE)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (ifc),
        .timeout_pulse(timeout_pulse),
        .timeout_id   (timeout_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] data;
    } wr_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] rq [N][256];
    int         rq_head [N];
    int         rq_tail [N];
    logic [N-1:0] en;
    wr_t        exp_q[$];
    int         ord[$];
    int         m_last;
    int         cyc = 0;
    int         wr_count = 0;
    int         last_wr_cyc = -1;
    bit         chk_gap = 1'b0;
    int         ready_cnt [N];
    int         pulse_cnt = 0;
    int         cyc_fall = 0;
    int         tmo_delay = -1;
    bit         busy_prev = 1'b0;

    // Behavioural transmitter: busy rises the cycle after a write and lasts a random frame.
    int   busy_cnt = 0;
    logic force_busy = 1'b0;
    logic no_busy = 1'b0;
    always @(posedge clk) begin
        if (ifc.tx_wr_en && !no_busy) busy_cnt <= int'($urandom_range(6, 1));
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign ifc.tx_busy = force_busy | (busy_cnt > 0);

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_byte(input int id, input bit last, input logic [7:0] data);
        rq[id][rq_tail[id]] = {last, data};
        rq_tail[id]++;
    endtask

    task automatic expect_wr(input int id, input logic [7:0] data);
        wr_t w;
        w.id   = 3'(id);
        w.data = data;
        exp_q.push_back(w);
    endtask

    function automatic bit any_pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) p = p | (rq_head[i] != rq_tail[i]);
        return p;
    endfunction

    // Packet-level round robin over everything queued: whole packets, next non-empty after last.
    task automatic plan();
        int h [N];
        int pick;
        int idx;
        bit last_b;
        for (int i = 0; i < N; i++) h[i] = rq_head[i];
        for (int guard = 0; guard < 1000; guard++) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (pick < 0 && h[idx] != rq_tail[idx]) pick = idx;
            end
            if (pick < 0) break;
            last_b = 1'b0;
            while (!last_b && h[pick] != rq_tail[pick]) begin
                expect_wr(pick, rq[pick][h[pick]][7:0]);
                last_b = rq[pick][h[pick]][8];
                h[pick]++;
            end
            m_last = pick;
        end
    endtask

    task automatic cycle();
        logic [N-1:0] v;
        logic [N-1:0] rdy;
        wr_t e;
        int gi;
        @(negedge clk);
        cyc++;
        if (ifc.tx_wr_en) begin
            gi = -1;
            for (int i = 0; i < N; i++) if (ifc.grant[i]) gi = i;
            ord.push_back(gi);
            check_eq("wr_while_busy", 32'(ifc.tx_busy), 32'd0);
            check_eq("wr_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("tx_din", 32'(ifc.tx_din), 32'(e.data));
                check_eq("grant_at_wr", 32'(ifc.grant), 32'd1 << e.id);
            end
            if (chk_gap && last_wr_cyc >= 0) check_eq("wr_spacing", 32'(cyc - last_wr_cyc), 32'(RISE + 3));
            last_wr_cyc = cyc;
            wr_count++;
        end
        if (ifc.tx_busy && !force_busy) check_eq("grant_held_busy", 32'(ifc.grant != '0), 32'd1);
        if (busy_prev && !ifc.tx_busy) cyc_fall = cyc;
        busy_prev = ifc.tx_busy;
        if (timeout_pulse) begin
            pulse_cnt++;
            tmo_delay = cyc - cyc_fall;
        end
        for (int i = 0; i < N; i++) begin
            if (en[i] && rq_head[i] != rq_tail[i]) begin
                v[i] = 1'b1;
                ifc.req_data[8*i +: 8] = rq[i][rq_head[i]][7:0];
                ifc.req_last[i] = rq[i][rq_head[i]][8];
            end else begin
                v[i] = 1'b0;
                ifc.req_data[8*i +: 8] = 8'($urandom);
                ifc.req_last[i] = 1'($urandom);
            end
        end
        ifc.req_valid = v;
        #1;
        rdy = ifc.req_ready;
        check_eq("ready_onehot", 32'($countones(rdy) <= 1), 32'd1);
        check_eq("ready_without_valid", 32'(rdy & ~v), 32'd0);
        if (ifc.tx_busy) check_eq("ready_while_busy", 32'(rdy), 32'd0);
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (v[i] && rdy[i]) begin
                ready_cnt[i]++;
                rq_head[i]++;
            end
        end
    endtask

    task automatic run(input string tag, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || any_pending() || ifc.grant != '0) && n < max) begin
            cycle();
            n++;
        end
        check_eq({tag, "_done"}, 32'(n < max), 32'd1);
        check_eq({tag, "_grant_idle"}, 32'(ifc.grant), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        ifc.req_valid = '1;
        #1;
        check_eq({tag, "_grant"}, 32'(ifc.grant), 32'd0);
        check_eq({tag, "_ready"}, 32'(ifc.req_ready), 32'd0);
        check_eq({tag, "_wr_en"}, 32'(ifc.tx_wr_en), 32'd0);
        check_eq({tag, "_din"}, 32'(ifc.tx_din), 32'd0);
        check_eq({tag, "_tmo_pulse"}, 32'(timeout_pulse), 32'd0);
        check_eq({tag, "_tmo_id"}, 32'(timeout_id), 32'd0);
        ifc.req_valid = '0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        check_reset_outputs(tag);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_last = N - 1;
        en = '1;
    endtask

    task automatic random_round();
        int np;
        int len;
        for (int i = 0; i < N; i++) begin
            np = int'($urandom_range(2, 0));
            for (int p = 0; p < np; p++) begin
                len = int'($urandom_range(4, 1));
                for (int b = 0; b < len; b++) push_byte(i, b == len - 1, 8'($urandom));
            end
        end
        plan();
        run("random", 4000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_exp [5];
        int n;
        int wr_before;
        rr_exp = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        en = '0;
        ifc.req_valid = '0;
        ifc.req_data  = '0;
        ifc.req_last  = '0;
        for (int i = 0; i < N; i++) begin
            rq_head[i] = 0;
            rq_tail[i] = 0;
            ready_cnt[i] = 0;
        end

        do_reset("reset");

        // Single-byte packet from requester 2.
        push_byte(2, 1'b1, 8'h5A);
        plan();
        run("single", 200);
        check_eq("single_ready_r2", 32'(ready_cnt[2]), 32'd1);
        check_eq("single_ready_other", 32'(ready_cnt[0] + ready_cnt[1] + ready_cnt[3]), 32'd0);
        check_eq("single_wr_count", 32'(wr_count), 32'd1);

        // Round-robin from reset over four single-byte requesters.
        do_reset("reset_rr");
        ord.delete();
        push_byte(0, 1'b1, 8'h10);
        push_byte(0, 1'b1, 8'h11);
        push_byte(1, 1'b1, 8'h21);
        push_byte(2, 1'b1, 8'h32);
        push_byte(3, 1'b1, 8'h43);
        plan();
        run("rr", 400);
        check_eq("rr_count", 32'(ord.size()), 32'd5);
        for (int i = 0; i < 5; i++) if (i < ord.size()) check_eq("rr_order", 32'(ord[i]), 32'(rr_exp[i]));

        // Packet lock: requester 1's three bytes go out before requester 0.
        ord.delete();
        push_byte(1, 1'b0, 8'h01);
        push_byte(1, 1'b0, 8'h02);
        push_byte(1, 1'b1, 8'h03);
        push_byte(0, 1'b1, 8'h77);
        plan();
        run("lock", 400);
        check_eq("lock_count", 32'(ord.size()), 32'd4);
        for (int i = 0; i < 4; i++) if (i < ord.size()) check_eq("lock_order", 32'(ord[i]), (i < 3) ? 32'd1 : 32'd0);

        for (int r = 0; r < 6; r++) random_round();

        // Transmitter never raises busy: pacing falls back to the rise window.
        no_busy = 1'b1;
        chk_gap = 1'b1;
        last_wr_cyc = -1;
        wr_before = wr_count;
        push_byte(0, 1'b0, 8'hA0);
        push_byte(0, 1'b1, 8'hA1);
        push_byte(1, 1'b1, 8'hB1);
        plan();
        run("nobusy", 200);
        check_eq("nobusy_wr_count", 32'(wr_count - wr_before), 32'd3);
        chk_gap = 1'b0;
        no_busy = 1'b0;

        // Stalled owner: requester 3 sends one non-last byte then goes quiet.
        do_reset("reset_tmo");
        en = 4'b1000;
        pulse_cnt = 0;
        tmo_delay = -1;
        ord.delete();
        push_byte(3, 1'b0, 8'hC3);
        push_byte(0, 1'b1, 8'h11);
        expect_wr(3, 8'hC3);
        expect_wr(0, 8'h11);
        n = 0;
        while (rq_head[3] != rq_tail[3] && n < 100) begin
            cycle();
            n++;
        end
        en = '1;
        while ((exp_q.size() != 0 || ifc.grant != '0) && n < 500) begin
            cycle();
            n++;
        end
        check_eq("tmo_done", 32'(n < 500), 32'd1);
        check_eq("tmo_pulse_count", 32'(pulse_cnt), 32'd1);
        check_eq("tmo_delay", 32'(tmo_delay), 32'(TMO + 1));
        check_eq("tmo_id", 32'(timeout_id), 32'd3);
        check_eq("tmo_next_owner", 32'(ord.size() == 2 ? ord[1] : -1), 32'd0);
        m_last = 0;

        // Reset while the owner waits for busy to fall.
        push_byte(1, 1'b1, 8'hA5);
        plan();
        wr_before = wr_count;
        n = 0;
        while ((wr_count == wr_before || !ifc.tx_busy) && n < 100) begin
            cycle();
            n++;
        end
        check_eq("rstmid_reach", 32'(n < 100), 32'd1);
        force_busy = 1'b1;
        cycle();
        cycle();
        check_eq("rstmid_locked", 32'(ifc.grant), 32'b0010);
        #2;
        rst = 1'b1;
        check_reset_outputs("rstmid");
        push_byte(2, 1'b1, 8'hB2);
        @(negedge clk);
        rst = 1'b0;
        m_last = N - 1;
        wr_before = wr_count;
        repeat (20) cycle();
        check_eq("rstmid_no_wr", 32'(wr_count - wr_before), 32'd0);
        check_eq("rstmid_pending", 32'(rq_head[2] != rq_tail[2]), 32'd1);
        force_busy = 1'b0;
        plan();
        run("rstmid_after", 200);
        check_eq("rstmid_wr", 32'(wr_count - wr_before), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
